// File: rtl/key_encoder.sv
// Push-button front end: sync + debounce MODE/SET, classify SET short/long,
// and emit one single-cycle command code per qualified event.

module key_debounce #(
  parameter int DB_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db
);
  localparam int CW = $clog2(DB_CYCLES);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // any bounce back to the accepted level restarts the stability count
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module key_encoder #(
  parameter int DB_CYCLES   = 20,
  parameter int LONG_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_set,
  output logic [1:0] code,
  output logic [1:0] pressed
);
  localparam int NUM_KEYS = 2;
  localparam int HW       = $clog2(LONG_CYCLES + 1);
  localparam int K_SET    = 0;
  localparam int K_MODE   = 1;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_SHORT = 2'b01;
  localparam logic [1:0] C_MODE  = 2'b10;
  localparam logic [1:0] C_LONG  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_HELD, S_LONG} set_st_t;

  logic [NUM_KEYS-1:0] raw, db, db_q;
  logic                mode_rise, set_rise;
  set_st_t             st, st_nxt;
  logic [HW-1:0]       hcnt, hcnt_nxt;
  logic [1:0]          set_ev, pend;

  assign raw = {btn_mode, btn_set};

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw[k]),
      .db   (db[k])
    );
  end

  assign pressed   = db;
  assign mode_rise = db[K_MODE] & ~db_q[K_MODE];
  assign set_rise  = db[K_SET]  & ~db_q[K_SET];

  always_comb begin
    st_nxt   = st;
    hcnt_nxt = hcnt;
    set_ev   = C_NONE;
    case (st)
      S_IDLE: if (set_rise) begin
        st_nxt   = S_HELD;
        hcnt_nxt = HW'(1);
      end
      S_HELD: begin
        if (!db[K_SET]) begin
          st_nxt = S_IDLE;
          set_ev = C_SHORT;
        end else if (hcnt == HW'(LONG_CYCLES - 1)) begin
          st_nxt = S_LONG;
          set_ev = C_LONG;
        end else if (hcnt != '1) begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
      S_LONG: if (!db[K_SET]) st_nxt = S_IDLE;
      default: st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= S_IDLE;
      hcnt <= '0;
      db_q <= '0;
      code <= C_NONE;
      pend <= C_NONE;
    end else begin
      st   <= st_nxt;
      hcnt <= hcnt_nxt;
      db_q <= db;
      // MODE wins a same-cycle collision; the SET code is replayed next cycle
      if (mode_rise) begin
        code <= C_MODE;
        pend <= set_ev;
      end else if (pend != C_NONE) begin
        code <= pend;
        pend <= C_NONE;
      end else begin
        code <= set_ev;
      end
    end
  end
endmodule

// File: tb/tb_key_encoder.sv
// Scoreboard bench for key_encoder: expected codes and their arrival cycles
// are queued when raw buttons are driven and matched as codes come out.

module tb_key_encoder;
  localparam int DB = 20;
  localparam int LG = 100;

  logic       clk = 1'b0;
  logic       rst_n, btn_mode, btn_set;
  logic [1:0] code, pressed;

  key_encoder #(.DB_CYCLES(DB), .LONG_CYCLES(LG)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_mode(btn_mode),
    .btn_set (btn_set),
    .code    (code),
    .pressed (pressed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int at; logic [1:0] c;} exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_code(input int at, input logic [1:0] c);
    exp_t e;
    e.at = at;
    e.c  = c;
    sb.push_back(e);
  endtask

  // every nonzero code must match the head of the scoreboard, value and cycle
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && code !== 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_code", 32'(code), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("code_val", 32'(code), 32'(e.c));
        chk("code_cyc", cyc, e.at);
      end
    end
  end

  int t;

  initial begin
    rst_n = 1'b0; btn_mode = 1'b0; btn_set = 1'b0;
    step(2);

    // reset with both buttons held
    btn_mode = 1'b1; btn_set = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_code", 32'(code), 32'd0);
      chk("rst_pressed", 32'(pressed), 32'd0);
    end
    rst_n = 1'b1;
    t = cyc + 1;
    expect_code(t + DB + 2, 2'b10);
    step(50);
    chk("rst_pressed_hold", 32'(pressed), 32'd3);
    btn_mode = 1'b0; btn_set = 1'b0;
    t = cyc + 1;
    expect_code(t + DB + 2, 2'b01);
    step(40);
    chk("rst_pressed_rel", 32'(pressed), 32'd0);

    // MODE with 5-cycle bounce, then a solid hold
    for (int i = 0; i < 8; i++) begin
      btn_mode = (i % 2 == 0);
      step(5);
      chk("bounce_pressed", 32'(pressed), 32'd0);
    end
    btn_mode = 1'b1;
    t = cyc + 1;
    expect_code(t + DB + 2, 2'b10);
    step(60);
    chk("mode_pressed", 32'(pressed), 32'd2);
    btn_mode = 1'b0;
    step(40);

    // SET short press
    btn_set = 1'b1;
    step(50);
    chk("short_pressed", 32'(pressed), 32'd1);
    btn_set = 1'b0;
    t = cyc + 1;
    expect_code(t + DB + 2, 2'b01);
    step(40);

    // SET long press: debounced rise after edge t+DB+1, long code LG edges later
    btn_set = 1'b1;
    t = cyc + 1;
    expect_code(t + DB + 1 + LG, 2'b11);
    step(21);
    chk("long_pre_rise", 32'(pressed[0]), 32'd0);
    step(1);
    chk("long_rise", 32'(pressed[0]), 32'd1);
    step(278);
    btn_set = 1'b0;
    step(40);

    // SET release coinciding with MODE press
    btn_set = 1'b1;
    step(50);
    btn_set = 1'b0; btn_mode = 1'b1;
    t = cyc + 1;
    expect_code(t + DB + 2, 2'b10);
    expect_code(t + DB + 3, 2'b01);
    step(60);
    btn_mode = 1'b0;
    step(40);

    // 19-cycle glitches on both buttons must never qualify
    for (int r = 0; r < 10; r++) begin
      btn_mode = 1'b1; btn_set = 1'b1;
      for (int j = 0; j < 19; j++) begin
        step(1);
        chk("glitch_pressed", 32'(pressed), 32'd0);
      end
      btn_mode = 1'b0; btn_set = 1'b0;
      for (int j = 0; j < 30; j++) begin
        step(1);
        chk("glitch_gap_pressed", 32'(pressed), 32'd0);
      end
    end

    step(10);
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
